// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the EX-stage multi-cycle multiply/divide unit.
// The operation codes match the ALU control field used by the rest of the pipeline.
package mul_div_unit_pkg;

  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_DIV = 4'b1011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_muldiv(input logic [3:0] ctl);
    return (ctl == ALU_MUL) || (ctl == ALU_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_step.sv
// One iteration of the shared multiply/divide datapath: shift-add for MUL,
// trial subtract with restore for DIV, on a {upper, lower} double-width accumulator.
module mul_div_step #(
  parameter int WIDTH = 32
) (
  input  logic                 op_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   part;
  logic [WIDTH+1:0] diff;
  logic             unused_ok;

  // MUL: lower half holds the remaining multiplier bits, upper half the running sum.
  // DIV: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    part     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = {1'b0, part} - {2'b00, opnd};
    acc_next = {sum, acc[WIDTH-1:1]};
    if (op_div) begin
      if (!diff[WIDTH+1])
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // A successful trial subtract always leaves a remainder below the divisor.
  assign unused_ok = diff[WIDTH];

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MUL/DIV unit: FSM, iteration counter, sign handling and the
// registered HI/LO result pair. One result bit is resolved per clock.
module mul_div_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALU_Control,
  input  logic             IsSigned,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivByZero
);

  import mul_div_unit_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               op_div;
  logic               neg_res;
  logic               sign_a;
  logic               b_zero;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc_nxt;

  logic               sgn_mode;
  logic               sa;
  logic               sb;
  logic               is_div;
  logic               accept;
  logic               finish;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_if_2w(input logic n, input logic [2*WIDTH-1:0] v);
    return n ? -v : v;
  endfunction

  assign sgn_mode = SIGNED_EN && IsSigned;
  assign sa       = sgn_mode && A[WIDTH-1];
  assign sb       = sgn_mode && B[WIDTH-1];
  assign mag_a    = neg_if(sa, A);
  assign mag_b    = neg_if(sb, B);
  assign is_div   = (ALU_Control == ALU_DIV);

  assign accept = Start && !Flush && is_muldiv(ALU_Control) &&
                  ((state == ST_IDLE) || (state == ST_DONE));
  assign finish = (state == ST_RUN) && !Flush && (cnt == '0);

  assign Busy = (state == ST_RUN);
  assign Done = (state == ST_DONE);

  mul_div_step #(.WIDTH(WIDTH)) u_step (
    .op_div   (op_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_nxt)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      sign_a  <= 1'b0;
      b_zero  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state <= ST_RUN;
            cnt   <= CNT_W'(WIDTH-1);
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (Flush)
            state <= ST_IDLE;
          else if (cnt == '0)
            state <= ST_DONE;
          else
            cnt <= cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
      if (accept) begin
        op_div  <= is_div;
        neg_res <= sa ^ sb;
        sign_a  <= sa;
        b_zero  <= (B == '0);
      end
    end
  end

  // Operand registers carry data only; their contents are meaningless outside RUN.
  always_ff @(posedge Clk) begin
    if (accept) begin
      opnd <= is_div ? mag_b : mag_a;
      acc  <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
    end else if (state == ST_RUN) begin
      acc <= acc_nxt;
    end
  end

  // Signs are applied to the final iteration's output as it is captured.
  // A zero divisor leaves |A| as remainder, so re-signing it returns A itself.
  always_comb begin
    prod = neg_if_2w(neg_res, acc_nxt);
    if (op_div) begin
      res_lo = b_zero ? {WIDTH{1'b1}} : neg_if(neg_res, acc_nxt[WIDTH-1:0]);
      res_hi = neg_if(sign_a, acc_nxt[2*WIDTH-1:WIDTH]);
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Hi        <= '0;
      Lo        <= '0;
      DivByZero <= 1'b0;
    end else if (finish) begin
      Hi        <= res_hi;
      Lo        <= res_lo;
      DivByZero <= op_div && b_zero;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised self-checking bench for mul_div_unit (32-bit and 8-bit instances)
// against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_mul_div_unit;

  localparam logic [3:0] MULOP = 4'b0101;
  localparam logic [3:0] DIVOP = 4'b1011;

  logic clk = 1'b0;
  logic rst;

  logic        st32, sg32, fl32;
  logic [3:0]  ctl32;
  logic [31:0] a32, b32;
  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;

  logic        st8, sg8, fl8;
  logic [3:0]  ctl8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int failures = 0;

  logic [63:0] e_hi, e_lo, p_hi, p_lo;
  logic        e_dz, p_dz;
  logic [63:0] e8_hi, e8_lo, p8_hi, p8_lo;
  logic        e8_dz;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
    .Clk(clk), .Reset(rst), .Start(st32), .ALU_Control(ctl32), .IsSigned(sg32),
    .A(a32), .B(b32), .Flush(fl32), .Busy(busy32), .Done(done32),
    .Hi(hi32), .Lo(lo32), .DivByZero(dz32)
  );

  mul_div_unit #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
    .Clk(clk), .Reset(rst), .Start(st8), .ALU_Control(ctl8), .IsSigned(sg8),
    .A(a8), .B(b8), .Flush(fl8), .Busy(busy8), .Done(done8),
    .Hi(hi8), .Lo(lo8), .DivByZero(dz8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: native signed/unsigned * / % on 64-bit integers, masked to w bits.
  task automatic model(input int w, input logic [3:0] ctl, input logic sg,
                       input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] hi, output logic [63:0] lo, output logic dz);
    longint av, bv, p, q, r;
    logic [63:0] m;
    m  = (64'd1 << w) - 64'd1;
    av = sg ? (longint'(a << (64 - w)) >>> (64 - w)) : longint'(a & m);
    bv = sg ? (longint'(b << (64 - w)) >>> (64 - w)) : longint'(b & m);
    dz = 1'b0;
    if (ctl == MULOP) begin
      p  = av * bv;
      lo = p & m;
      hi = (p >> w) & m;
    end else if ((b & m) == 64'd0) begin
      lo = m;
      hi = a & m;
      dz = 1'b1;
    end else begin
      q  = av / bv;
      r  = av % bv;
      lo = q & m;
      hi = r & m;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch32(input logic [3:0] ctl, input logic sg, input logic [31:0] a, input logic [31:0] b);
    p_hi = e_hi; p_lo = e_lo; p_dz = e_dz;
    model(32, ctl, sg, 64'(a), 64'(b), e_hi, e_lo, e_dz);
    ctl32 = ctl; sg32 = sg; a32 = a; b32 = b; st32 = 1'b1;
    tick();
    st32 = 1'b0;
  endtask

  task automatic wait32(input string tag, input int poke);
    int n, nbusy;
    logic stable;
    n = 1; nbusy = 0; stable = 1'b1;
    while (done32 !== 1'b1 && n < 80) begin
      if (busy32 === 1'b1) nbusy++;
      if (hi32 !== p_hi[31:0] || lo32 !== p_lo[31:0]) stable = 1'b0;
      st32 = (n == poke);
      if (n == poke) begin
        ctl32 = MULOP; a32 = $urandom; b32 = $urandom;
      end
      tick();
      n++;
    end
    st32 = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_busycycles"}, 64'(nbusy), 64'd32);
    check({tag, "_busy_at_done"}, 64'(busy32), 64'd0);
    check({tag, "_hold_in_run"}, 64'(stable), 64'd1);
    check({tag, "_hi"}, 64'(hi32), e_hi);
    check({tag, "_lo"}, 64'(lo32), e_lo);
    check({tag, "_dz"}, 64'(dz32), 64'(e_dz));
  endtask

  task automatic after32(input string tag);
    tick();
    check({tag, "_donepulse"}, 64'({busy32, done32}), 64'd0);
  endtask

  task automatic run8(input string tag, input logic [3:0] ctl, input logic sg, input logic [7:0] a, input logic [7:0] b);
    int n, nbusy;
    logic stable;
    p8_hi = e8_hi; p8_lo = e8_lo;
    model(8, ctl, sg, 64'(a), 64'(b), e8_hi, e8_lo, e8_dz);
    ctl8 = ctl; sg8 = sg; a8 = a; b8 = b; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    n = 1; nbusy = 0; stable = 1'b1;
    while (done8 !== 1'b1 && n < 40) begin
      if (busy8 === 1'b1) nbusy++;
      if (hi8 !== p8_hi[7:0] || lo8 !== p8_lo[7:0]) stable = 1'b0;
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd9);
    check({tag, "_busycycles"}, 64'(nbusy), 64'd8);
    check({tag, "_hold_in_run"}, 64'(stable), 64'd1);
    check({tag, "_hi"}, 64'(hi8), e8_hi);
    check({tag, "_lo"}, 64'(lo8), e8_lo);
    check({tag, "_dz"}, 64'(dz8), 64'(e8_dz));
    tick();
    check({tag, "_donepulse"}, 64'({busy8, done8}), 64'd0);
  endtask

  initial begin
    int seen;
    logic [31:0] ra, rb;
    logic [7:0]  qa, qb;
    rst = 1'b1;
    st32 = 1'b0; sg32 = 1'b0; fl32 = 1'b0; ctl32 = 4'd0; a32 = '0; b32 = '0;
    st8  = 1'b0; sg8  = 1'b0; fl8  = 1'b0; ctl8  = 4'd0; a8  = '0; b8  = '0;
    e_hi = '0; e_lo = '0; e_dz = 1'b0; p_hi = '0; p_lo = '0; p_dz = 1'b0;
    e8_hi = '0; e8_lo = '0; e8_dz = 1'b0; p8_hi = '0; p8_lo = '0;
    repeat (3) tick();
    check("reset_ctrl", 64'({busy32, done32, dz32, busy8, done8, dz8}), 64'd0);
    check("reset_hilo", {hi32, lo32}, 64'd0);
    rst = 1'b0;
    tick();

    launch32(MULOP, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait32("mul_u_max", 0);
    check("mul_u_max_const", {hi32, lo32}, 64'hFFFFFFFE_00000001);
    after32("mul_u_max");

    launch32(MULOP, 1'b1, 32'hFFFFFFFD, 32'd7);
    wait32("mul_s_m3x7", 0);
    check("mul_s_m3x7_const", {hi32, lo32}, 64'hFFFFFFFF_FFFFFFEB);
    after32("mul_s_m3x7");

    launch32(DIVOP, 1'b1, 32'hFFFFFFF9, 32'd2);
    wait32("div_s_m7d2", 0);
    check("div_s_m7d2_const", {hi32, lo32}, 64'hFFFFFFFF_FFFFFFFD);
    after32("div_s_m7d2");

    launch32(DIVOP, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait32("div_s_ovf", 0);
    check("div_s_ovf_const", {hi32, lo32}, 64'h00000000_80000000);
    after32("div_s_ovf");

    launch32(DIVOP, 1'b1, 32'd100, 32'd0);
    wait32("div_by_zero", 0);
    check("div_by_zero_const", {31'd0, dz32, hi32}, {31'd0, 1'b1, 32'h00000064});
    after32("div_by_zero");

    launch32(DIVOP, 1'b0, 32'd1000003, 32'd17);
    wait32("start_in_run", 5);
    after32("start_in_run");

    launch32(MULOP, 1'b1, 32'd12345, 32'hFFFFFD5A);
    wait32("b2b_first", 0);
    launch32(DIVOP, 1'b1, 32'hFFFFFC18, 32'd33);
    wait32("b2b_second", 0);
    after32("b2b_second");

    // Flush sampled at the edge closing RUN cycle 10.
    launch32(MULOP, 1'b0, 32'd7, 32'd9);
    repeat (9) tick();
    check("flush_busy_c10", 64'(busy32), 64'd1);
    fl32 = 1'b1;
    tick();
    fl32 = 1'b0;
    check("flush_busy_c11", 64'(busy32), 64'd0);
    seen = 0;
    repeat (40) begin
      if (done32 === 1'b1 || busy32 === 1'b1) seen++;
      tick();
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_hi_kept", 64'(hi32), p_hi);
    check("flush_lo_kept", 64'(lo32), p_lo);
    e_hi = p_hi; e_lo = p_lo; e_dz = p_dz;

    ctl32 = MULOP; a32 = 32'd5; b32 = 32'd6; st32 = 1'b1; fl32 = 1'b1;
    ctl8 = 4'b0010; a8 = 8'd3; b8 = 8'd4; st8 = 1'b1;
    tick();
    st32 = 1'b0; fl32 = 1'b0; st8 = 1'b0;
    seen = 0;
    repeat (40) begin
      if (busy32 === 1'b1 || done32 === 1'b1) seen++;
      tick();
    end
    check("flush_blocks_start", 64'(seen), 64'd0);

    ctl32 = 4'b0010; st32 = 1'b1;
    tick();
    st32 = 1'b0;
    seen = 0;
    repeat (40) begin
      if (busy32 === 1'b1 || done32 === 1'b1 || busy8 === 1'b1 || done8 === 1'b1) seen++;
      tick();
    end
    check("invalid_ctl_ignored", 64'(seen), 64'd0);
    check("invalid_ctl_hilo", {hi32, lo32}, {e_hi[31:0], e_lo[31:0]});

    // Asynchronous reset in the middle of a cycle, well away from any edge.
    launch32(DIVOP, 1'b1, 32'hFFFF0000, 32'd3);
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrun_reset_ctrl", 64'({busy32, done32, dz32}), 64'd0);
    check("midrun_reset_hilo", {hi32, lo32}, 64'd0);
    tick();
    rst = 1'b0;
    e_hi = '0; e_lo = '0; e_dz = 1'b0;
    tick();

    run8("div8_200d7", DIVOP, 1'b0, 8'd200, 8'd7);
    check("div8_200d7_const", 64'({hi8, lo8}), 64'h041C);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      launch32(($urandom_range(0, 1) != 0) ? DIVOP : MULOP, 1'($urandom_range(0, 1)), ra, rb);
      wait32("rnd32", 0);
      after32("rnd32");
    end

    for (int i = 0; i < 30; i++) begin
      qa = 8'($urandom);
      qb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run8("rnd8", ($urandom_range(0, 1) != 0) ? DIVOP : MULOP, 1'($urandom_range(0, 1)), qa, qb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Parametrised multi-cycle multiply/divide unit for the MIPS pipeline EX stage. It executes the MUL (ALU_Control 4'b0101) and DIV (4'b1011) operations that the single-cycle ALU cannot complete in one cycle. It produces a HI/LO result pair after a fixed iterative latency. Busy stalls the pipeline and Flush aborts an operation when a branch or jump squashes it.

Parameters:
WIDTH, 32, operand width in bits; Hi/Lo are WIDTH each; must be >= 4
SIGNED_EN, 1, 1 = IsSigned input honoured; 0 = all operations unsigned

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high; forces IDLE and clears all outputs
Start  input  1  request; sampled only in IDLE or DONE
ALU_Control  input  4  operation select: 4'b0101 MUL, 4'b1011 DIV, any other value ignored
IsSigned  input  1  two's-complement operation when 1 (and SIGNED_EN=1)
A  input  WIDTH  multiplicand / dividend
B  input  WIDTH  multiplier / divisor
Flush  input  1  synchronous abort of an operation in progress
Busy  output  1  high while iterating
Done  output  1  one-cycle pulse; Hi/Lo/DivByZero valid
Hi  output  WIDTH  MUL: upper product half; DIV: remainder
Lo  output  WIDTH  MUL: lower product half; DIV: quotient
DivByZero  output  1  DIV with B==0; updated with Done

Behaviour:
- Clock is Clk. Reset is asynchronous and active-high. While Reset is high: state=IDLE, Busy=0, Done=0, Hi=0, Lo=0, DivByZero=0, counter=0.
- States:
  - IDLE: accepts Start.
  - RUN: WIDTH iterations.
  - DONE: 1 cycle, Done=1; then returns to IDLE.
- Accept rule: a request is accepted when Start=1 on a rising edge while in IDLE or DONE, Flush=0, and ALU_Control is MUL or DIV.
- On accept, the unit latches the op, sign mode, operand magnitudes and result signs, and loads the counter with WIDTH-1.
- Start asserted in DONE is accepted, so back-to-back operations are supported.
- Start is ignored while in RUN.
- Latency: request accepted at edge k → Busy=1 for cycles k+1..k+WIDTH → Done=1 in cycle k+WIDTH+1 → Busy=0 in that cycle.
- MUL: shift-add, one multiplier bit per cycle, using a 2*WIDTH accumulator.
- DIV: restoring division, one quotient bit per cycle.
- Signed mode:
  - Operands are converted to magnitude on accept.
  - Signs are applied on the RUN→DONE transition.
  - Product sign = sign(A) XOR sign(B).
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
- Overflow (MIN/-1): Lo=MIN, Hi=0. This falls out of wrap-around negation; no special case is required.
- Divide by zero: full latency is kept. Lo = all ones, Hi = A unmodified, DivByZero=1. No exception is raised.
- Hi/Lo/DivByZero are registered and hold their value until the next Done or Reset. They are not disturbed during RUN.
- Flush:
  - Flush=1 in RUN → IDLE on the next edge; Busy=0 and no Done pulse; Hi/Lo keep their previous values.
  - Flush and Start asserted together: Flush wins and nothing is accepted.
  - Flush in IDLE or DONE has no effect beyond blocking Start.
- Reset mid-RUN: immediate return to IDLE with cleared outputs; the in-flight result is lost.
- The counter is log2(WIDTH) bits wide and saturates at 0; it never wraps.

Decomposition:
- Shared package contents:
  - ALU_MUL=4'b0101 and ALU_DIV=4'b1011, identical to the ALU control encoding.
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One sub-module, mul_div_step: combinational single-iteration datapath (add-or-shift for MUL, trial subtract/restore for DIV), parametrised by WIDTH. The top level holds the FSM, counter, sign handling and output registers.

Test Plan:
1. Unsigned MUL, WIDTH=32, A=0xFFFFFFFF, B=0xFFFFFFFF, Start at edge 0 → Busy during cycles 1..32, Done in cycle 33, Hi=0xFFFFFFFE, Lo=0x00000001.
2. Signed checks, IsSigned=1:
   - MUL -3×7 → Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
   - DIV -7/2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
3. Signed edge cases:
   - DIV 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0x00000000, DivByZero=0.
   - DIV 100/0 → Lo=0xFFFFFFFF, Hi=0x00000064, DivByZero=1, same latency.
4. Handshake:
   - Start pulsed during RUN → ignored; result matches the first operation.
   - Start held in the DONE cycle → second op accepted; its Done arrives 33 cycles later.
5. Abort and reset:
   - Flush at cycle 10 of RUN → Busy=0 from cycle 11, no Done, Hi/Lo unchanged.
   - Reset asserted mid-RUN between edges → all outputs 0 immediately.
6. WIDTH=8 instance, unsigned DIV 200/7 → Done in cycle 9, Lo=0x1C, Hi=0x04. Invalid ALU_Control=4'b0010 with Start → no Busy, no Done.
